// File: rtl/motor_cmd_pkg.sv
// Shared constants, opcode table and FSM state encoding for the motor command decoder.
package motor_cmd_pkg;

  localparam logic [7:0] SOM         = 8'h55;
  localparam logic [7:0] OP_TICS     = 8'h11;
  localparam logic [7:0] OP_SETPT1   = 8'h21;
  localparam logic [7:0] OP_SETPT2   = 8'h22;
  localparam logic [7:0] OP_ACCEL    = 8'h23;
  localparam logic [7:0] OP_RD_ENC_L = 8'h24;
  localparam logic [7:0] OP_RD_ENC_R = 8'h25;
  localparam logic [7:0] OP_ZERO_ENC = 8'h26;

  localparam int TIMER_W   = 20;
  localparam int RSP_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE, CMD, PAYLOAD, CHK, EXEC, TX_SEND, TX_WAIT
  } state_t;

  function automatic logic cmd_known(input logic [7:0] op);
    case (op)
      OP_TICS, OP_SETPT1, OP_SETPT2, OP_ACCEL,
      OP_RD_ENC_L, OP_RD_ENC_R, OP_ZERO_ENC: cmd_known = 1'b1;
      default:                               cmd_known = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] payload_len(input logic [7:0] op);
    case (op)
      OP_TICS:                       payload_len = 2'd2;
      OP_SETPT1, OP_SETPT2, OP_ACCEL: payload_len = 2'd1;
      default:                       payload_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/motor_cmd_if.sv
// UART byte handshake bundle: host side (master) drives rx bytes and tx_done, decoder side (slave) transmits.
interface motor_cmd_if;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_done;

  modport master (output rx_dv, rx_byte, tx_done, input tx_dv, tx_byte);
  modport slave  (input rx_dv, rx_byte, tx_done, output tx_dv, tx_byte);
endinterface

// File: rtl/cmd_rsp_serializer.sv
// Sends a 24-bit snapshot as three bytes MSB-first, one o_Tx_DV strobe per byte, each gated by tx_done.
module cmd_rsp_serializer
  import motor_cmd_pkg::*;
(
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] data,
  output state_t      phase_nxt,
  motor_cmd_if.slave  uart
);

  state_t      state_q, state_d;
  logic [23:0] sh_q;
  logic [1:0]  sent_q;

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        sh_q   <= data;
        sent_q <= '0;
      end else if (state_q == TX_WAIT && uart.tx_done) begin
        sh_q   <= {sh_q[15:0], 8'h00};
        sent_q <= sent_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = TX_SEND;
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: if (uart.tx_done)
                 state_d = (sent_q == 2'(RSP_BYTES - 1)) ? IDLE : TX_SEND;
      default: state_d = IDLE;
    endcase
  end

  // The current byte always sits in the top of the shift register, so it is stable until tx_done.
  assign phase_nxt    = state_d;
  assign uart.tx_dv   = (state_q == TX_SEND);
  assign uart.tx_byte = sh_q[23:16];

endmodule

// File: rtl/motor_cmd_decoder.sv
// Host UART command decoder: parses SOM/CMD/payload packets, updates drive settings, answers encoder
// reads. Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every packet.
module motor_cmd_decoder
  import motor_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = 200000,
  parameter logic [7:0] SETPT_RST    = 8'h80
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic [23:0] i_EncCntL,
  input  logic [23:0] i_EncCntR,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done,
  output logic [7:0]  o_setpt1,
  output logic [7:0]  o_setpt2,
  output logic [7:0]  o_accel,
  output logic [15:0] o_tics_per_rev,
  output logic        o_zero_encoders,
  output logic        o_cmd_mode_en,
  output logic        o_cmd_err
);

`ifdef CMD_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = CHK;
`else
  localparam state_t AFTER_PAYLOAD = EXEC;
`endif

  motor_cmd_if uart ();

  assign uart.rx_dv   = i_Rx_DV;
  assign uart.rx_byte = i_Rx_Byte;
  assign uart.tx_done = i_Tx_Done;
  assign o_Tx_DV      = uart.tx_dv;
  assign o_Tx_Byte    = uart.tx_byte;

  state_t             state_q, state_d, rsp_phase;
  logic [7:0]         cmd_q, cmd_d;
  logic [1:0]         left_q, left_d;
  logic [15:0]        pay_q, pay_d;
  logic [TIMER_W-1:0] timer_q;
  logic               parsing, timeout, err_d, is_read, rsp_start;
  logic [23:0]        rsp_data;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  // A byte landing in the timeout cycle wins: timeout is only declared on a silent cycle.
  assign parsing = state_q inside {CMD, PAYLOAD, CHK};
  assign timeout = parsing && !uart.rx_dv && (timer_q == TIMER_W'(TIMEOUT_CLKS));
  assign is_read = (cmd_q == OP_RD_ENC_L) || (cmd_q == OP_RD_ENC_R);
  assign rsp_data = (cmd_q == OP_RD_ENC_L) ? i_EncCntL : i_EncCntR;
  assign o_zero_encoders = (state_q == EXEC) && (cmd_q == OP_ZERO_ENC);

  cmd_rsp_serializer u_rsp (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .start     (rsp_start),
    .data      (rsp_data),
    .phase_nxt (rsp_phase),
    .uart      (uart)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cmd_d     = cmd_q;
    left_d    = left_q;
    pay_d     = pay_q;
    err_d     = 1'b0;
    rsp_start = 1'b0;
`ifdef CMD_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      IDLE: if (uart.rx_dv && uart.rx_byte == SOM) state_d = CMD;
      CMD: begin
        if (uart.rx_dv) begin
          if (cmd_known(uart.rx_byte)) begin
            cmd_d   = uart.rx_byte;
            left_d  = payload_len(uart.rx_byte);
            state_d = (payload_len(uart.rx_byte) == 2'd0) ? AFTER_PAYLOAD : PAYLOAD;
`ifdef CMD_CHECKSUM_EN
            chk_d   = uart.rx_byte;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      PAYLOAD: begin
        if (uart.rx_dv) begin
          pay_d  = {pay_q[7:0], uart.rx_byte};
          left_d = left_q - 2'd1;
          if (left_q == 2'd1) state_d = AFTER_PAYLOAD;
`ifdef CMD_CHECKSUM_EN
          chk_d  = chk_q ^ uart.rx_byte;
`endif
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef CMD_CHECKSUM_EN
      CHK: begin
        if (uart.rx_dv) begin
          if (uart.rx_byte == chk_q) begin
            state_d = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      EXEC: begin
        if (is_read) begin
          rsp_start = 1'b1;
          state_d   = TX_SEND;
        end else begin
          state_d = IDLE;
        end
      end
      TX_SEND, TX_WAIT: state_d = rsp_phase;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      left_q         <= '0;
      pay_q          <= '0;
      timer_q        <= '0;
      o_setpt1       <= SETPT_RST;
      o_setpt2       <= SETPT_RST;
      o_accel        <= '0;
      o_tics_per_rev <= '0;
      o_cmd_mode_en  <= 1'b0;
      o_cmd_err      <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      chk_q          <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      left_q    <= left_d;
      pay_q     <= pay_d;
      o_cmd_err <= err_d;
`ifdef CMD_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
      if (!parsing || uart.rx_dv || timeout) timer_q <= '0;
      else                                   timer_q <= timer_q + 1'b1;
      if (state_q == EXEC) begin
        case (cmd_q)
          OP_TICS:   o_tics_per_rev <= pay_q;
          OP_SETPT1: begin o_setpt1 <= pay_q[7:0]; o_cmd_mode_en <= 1'b1; end
          OP_SETPT2: begin o_setpt2 <= pay_q[7:0]; o_cmd_mode_en <= 1'b1; end
          OP_ACCEL:  o_accel <= pay_q[7:0];
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: doc/motor_cmd_decoder.md
MOTOR_CMD_DECODER -- requirements
Module: motor_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 200000: max clocks allowed between bytes of one packet.
REQ-002 SHALL have parameter SETPT_RST, default 8'h80: reset value of both speed setpoints (stopped, forward).
REQ-003 SHALL have port clk_100MHz, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_Rx_DV, input, 1: one-cycle strobe, received UART byte valid.
REQ-006 SHALL have port i_Rx_Byte, input, 8: received byte, valid with i_Rx_DV.
REQ-007 SHALL have ports i_EncCntL and i_EncCntR, input, 24 each: live encoder counts.
REQ-008 SHALL have port o_Tx_DV, output, 1: one-cycle strobe to the UART transmitter.
REQ-009 SHALL have port o_Tx_Byte, output, 8: byte to transmit, held stable until i_Tx_Done.
REQ-010 SHALL have port i_Tx_Done, input, 1: one-cycle strobe, transmitter finished the byte.
REQ-011 SHALL have ports o_setpt1 and o_setpt2, output, 8 each: speed setpoints (bit 7 = direction).
REQ-012 SHALL have port o_accel, output, 8: acceleration setting.
REQ-013 SHALL have port o_tics_per_rev, output, 16: encoder tics per wheel revolution.
REQ-014 SHALL have port o_zero_encoders, output, 1: one-cycle pulse that clears the encoder counters.
REQ-015 SHALL have port o_cmd_mode_en, output, 1: host command mode active.
REQ-016 SHALL have port o_cmd_err, output, 1: one-cycle pulse on a protocol error.

Function
REQ-017 SHALL parse packets of the form SOM 0x55, CMD, payload; payload length is 0x11: 2 bytes (high byte first), 0x21/0x22/0x23: 1 byte, 0x24/0x25/0x26: 0 bytes.
REQ-018 SHALL use FSM states IDLE, CMD, PAYLOAD, CHK, EXEC, TX_SEND, TX_WAIT; in IDLE, any byte other than 0x55 SHALL be discarded silently.
REQ-019 SHALL, on an unknown CMD byte, pulse o_cmd_err and return to IDLE; no outputs SHALL change.
REQ-020 SHALL enter EXEC in the cycle after the i_Rx_DV of the last packet byte, and SHALL update registers in that same cycle, so outputs are visible 2 cycles after the strobe.
REQ-021 SHALL handle 0x21 and 0x22 by loading o_setpt1 and o_setpt2 respectively and setting o_cmd_mode_en=1 (sticky until reset).
REQ-022 SHALL handle 0x26 by pulsing o_zero_encoders for exactly 1 cycle in EXEC.
REQ-023 SHALL handle 0x24 and 0x25 by snapshotting i_EncCntL or i_EncCntR in EXEC, then sending 3 bytes MSB-first.
REQ-024 SHALL, for each response byte, assert o_Tx_DV for 1 cycle in TX_SEND, then wait in TX_WAIT for i_Tx_Done; after the 3rd i_Tx_Done it SHALL return to IDLE.
REQ-025 SHALL ignore i_Rx_DV bytes received while in EXEC, TX_SEND or TX_WAIT; these SHALL NOT raise an error.
REQ-026 SHALL run a 20-bit timeout counter that clears on every accepted byte and counts only in CMD, PAYLOAD and CHK.
REQ-027 SHALL, when the timeout counter reaches TIMEOUT_CLKS, pulse o_cmd_err and go to IDLE.
REQ-028 SHALL give the byte priority when i_Rx_DV and the timeout occur in the same cycle: the byte is accepted and no error is raised.
REQ-029 SHALL, in CMD state, treat a received 0x55 as a CMD byte; it is unknown, so REQ-019 applies and no resync occurs.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, set state=IDLE, o_setpt1=o_setpt2=SETPT_RST, o_accel=0, o_tics_per_rev=0, o_cmd_mode_en=0, o_Tx_DV=0, o_Tx_Byte=0, o_zero_encoders=0, o_cmd_err=0, and clear the timer.
REQ-031 SHALL abort any packet or response in progress when reset is asserted mid-operation; no further o_Tx_DV SHALL follow.

Configuration
REQ-032 SHALL, with CMD_CHECKSUM_EN defined, require a trailing byte equal to the XOR of CMD and all payload bytes, checked in CHK; on mismatch it SHALL pulse o_cmd_err and execute nothing.
REQ-033 SHALL, without CMD_CHECKSUM_EN, not implement the CHK state; packets end at the last payload byte.

Structure
REQ-034 SHALL take SOM, the opcode constants, the payload-length function and the state enum from the shared package motor_cmd_pkg.
REQ-035 SHALL implement the 3-byte response handshake (REQ-024) in sub-module cmd_rsp_serializer.

Verification
REQ-036 SHALL cover: bytes 55 21 90 (plus B1 with the macro) -> o_setpt1=8'h90 two cycles after the last strobe, and o_cmd_mode_en=1.
REQ-037 SHALL cover: 55 11 01 E0 -> o_tics_per_rev=16'h01E0; o_setpt1/o_setpt2 unchanged.
REQ-038 SHALL cover: i_EncCntR=24'h12ABCD, then 55 25 -> Tx bytes 12, AB, CD, each issued only after the preceding i_Tx_Done.
REQ-039 SHALL cover: 55 then silence for TIMEOUT_CLKS -> one o_cmd_err pulse; a following 55 26 -> one o_zero_encoders pulse.
REQ-040 SHALL cover: 55 7F -> o_cmd_err; with the macro, 55 21 90 00 -> o_cmd_err and o_setpt1 unchanged.
REQ-041 SHALL cover: rst_n=0 during TX_WAIT -> all outputs return to reset values; no further o_Tx_DV.
